// File: rtl/multi_chunk_adder.sv
// Multi-cycle long-integer add/sub, one CHUNK-bit slice per clock, LSB slice first.
// Optional signed-overflow output `ovf` is built when MCA_OVF_EN is defined.
module multi_chunk_adder #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic             c_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
`ifdef MCA_OVF_EN
  logic             ovf_q;
`endif

  logic [CHUNK:0]   slice_d;
  logic             last_d;

  // Operands shift down so the adder always reads the low slice.
  assign slice_d = {1'b0, a_q[CHUNK-1:0]}
                 + {1'b0, b_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_q};
  assign last_d  = (k_q == KW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MCA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_RUN: begin
          sum_q[k_q*CHUNK +: CHUNK] <= slice_d[CHUNK-1:0];
          c_q <= slice_d[CHUNK];
          a_q <= a_q >> CHUNK;
          b_q <= b_q >> CHUNK;
          k_q <= k_q + KW'(1);
          if (last_d) begin
            state_q <= S_DONE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= slice_d[CHUNK];
`ifdef MCA_OVF_EN
            // carry into msb is a^b^s at msb; compare with carry out
            ovf_q   <= a_q[CHUNK-1] ^ b_q[CHUNK-1]
                     ^ slice_d[CHUNK-1] ^ slice_d[CHUNK];
`endif
          end
        end
        default: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= cin ^ sub;
            k_q     <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef MCA_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_multi_chunk_adder.sv
// Bench for multi_chunk_adder: 256/32 instance and a single-slice 64/64 instance.
// Overflow checks are compiled in when MCA_OVF_EN is defined.
module tb_multi_chunk_adder;

  localparam int W  = 256;
  localparam int W2 = 64;
  localparam int N0 = 8;
  localparam int N1 = 1;

  localparam logic [W-1:0] ONES   = '1;
  localparam logic [W-1:0] MSB    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ALTA   = {8{32'hAAAA_AAAA}};
  localparam logic [W-1:0] ALTB   = {8{32'h5555_5555}};
  localparam logic [W-1:0] ONES64 = {{(W-W2){1'b0}}, {W2{1'b1}}};
  localparam logic [W-1:0] MSB64  = {{(W-W2){1'b0}}, 1'b1, {(W2-1){1'b0}}};
  localparam logic [W-1:0] MAXP64 = {{(W-W2){1'b0}}, 1'b0, {(W2-1){1'b1}}};

  typedef struct {
    logic         sel;
    logic         sb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0, start1, sub, cin;
  logic [W-1:0]  a, b;
  logic          busy0, done0, cout0;
  logic          busy1, done1, cout1;
  logic [W-1:0]  sum0;
  logic [W2-1:0] sum1;
`ifdef MCA_OVF_EN
  logic          ovf0, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_chunk_adder #(.WIDTH(W), .CHUNK(32)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (start0),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy0),
    .done  (done0),
    .sum   (sum0),
`ifdef MCA_OVF_EN
    .ovf   (ovf0),
`endif
    .cout  (cout0)
  );

  multi_chunk_adder #(.WIDTH(W2), .CHUNK(W2)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .sub   (sub),
    .a     (a[W2-1:0]),
    .b     (b[W2-1:0]),
    .cin   (cin),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
`ifdef MCA_OVF_EN
    .ovf   (ovf1),
`endif
    .cout  (cout1)
  );

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic sel, input logic sb,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci);
    sub = sb;
    a   = av;
    b   = bv;
    cin = ci;
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
    // scramble inputs to prove they were latched
    a   = ~av;
    b   = ~bv;
    sub = ~sb;
    cin = ~ci;
  endtask

  task automatic wait_done(input logic sel, output int edges,
                           output int busies, output logic d);
    edges  = 0;
    busies = 0;
    d      = 1'b0;
    while (edges < 40) begin
      d = sel ? done1 : done0;
      if (d) break;
      busies += int'(sel ? busy1 : busy0);
      step();
      edges++;
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int           e, bc, n;
    logic         d;
    logic [W-1:0] s;
    launch(v.sel, v.sb, v.a, v.b, v.ci);
    wait_done(v.sel, e, bc, d);
    n = v.sel ? N1 : N0;
    chk({nm, "_done"}, W'(d), W'(1));
    chk({nm, "_lat"}, W'(e + 1), W'(n + 1));
    chk({nm, "_busycnt"}, W'(bc), W'(n));
    chk({nm, "_busydone"}, W'(v.sel ? busy1 : busy0), W'(0));
    s = v.sel ? W'(sum1) : sum0;
    chk({nm, "_sum"}, s, v.s);
    chk({nm, "_cout"}, W'(v.sel ? cout1 : cout0), W'(v.co));
`ifdef MCA_OVF_EN
    chk({nm, "_ovf"}, W'(v.sel ? ovf1 : ovf0), W'(v.ov));
`endif
    step();
    chk({nm, "_pulse"}, W'(v.sel ? done1 : done0), W'(0));
    s = v.sel ? W'(sum1) : sum0;
    chk({nm, "_hold"}, s, v.s);
  endtask

  vec_t tv[$];

  initial begin
    int   e, bc, cyc, dcnt, dcyc;
    logic d;
    logic [W-1:0] cap;

    tv.push_back('{1'b0, 1'b0, ONES,  W'(1), 1'b0, W'(0),          1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, W'(256'hFFFF_FFFF), W'(0), 1'b1,
                   W'(256'h1_0000_0000), 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, W'(0),  W'(1), 1'b0, ONES,          1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, MAXP,   W'(1), 1'b0, MSB,           1'b0, 1'b1});
    tv.push_back('{1'b0, 1'b1, MSB,    W'(1), 1'b0, MAXP,          1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, W'(1),  W'(1), 1'b0, W'(2),         1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, W'(3),  W'(3), 1'b1, ONES,          1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, ALTA,   ALTB,  1'b1, W'(0),         1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, MSB,    MSB,   1'b0, W'(0),         1'b1, 1'b1});
    tv.push_back('{1'b1, 1'b0, MAXP64, W'(1), 1'b0, MSB64,         1'b0, 1'b1});
    tv.push_back('{1'b1, 1'b1, MSB64,  W'(1), 1'b0, MAXP64,        1'b1, 1'b1});
    tv.push_back('{1'b1, 1'b0, W'(1),  W'(1), 1'b0, W'(2),         1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, ONES64, W'(1), 1'b0, W'(0),         1'b1, 1'b0});

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("rst_busy", W'(busy0), W'(0));
    chk("rst_done", W'(done0), W'(0));
    chk("rst_sum",  sum0, W'(0));
    chk("rst_cout", W'(cout0), W'(0));
    chk("rst_sum64", W'(sum1), W'(0));
`ifdef MCA_OVF_EN
    chk("rst_ovf", W'(ovf0), W'(0));
`endif
    rst = 1'b0;
    step();

    for (int i = 0; i < tv.size(); i++)
      run(tv[i], $sformatf("vec%0d", i));

    // back-to-back: second start issued in the done cycle
    launch(1'b0, 1'b1, W'(0), W'(1), 1'b0);
    wait_done(1'b0, e, bc, d);
    chk("b2b1_done", W'(d), W'(1));
    chk("b2b1_sum", sum0, ONES);
    chk("b2b1_cout", W'(cout0), W'(0));
    launch(1'b0, 1'b1, W'(5), W'(3), 1'b1);
    chk("b2b2_pulse", W'(done0), W'(0));
    chk("b2b2_busy", W'(busy0), W'(1));
    wait_done(1'b0, e, bc, d);
    chk("b2b2_done", W'(d), W'(1));
    chk("b2b2_lat", W'(e + 1), W'(N0 + 1));
    chk("b2b2_sum", sum0, W'(1));
    chk("b2b2_cout", W'(cout0), W'(1));
    step();

    // start pulses while busy are ignored
    launch(1'b0, 1'b0, ALTA, W'(1), 1'b0);
    dcnt = 0; dcyc = 0; cap = '0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 3 || cyc == 5) begin
        start0 = 1'b1; a = ONES; b = ONES; sub = 1'b1; cin = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      if (done0) begin
        dcnt++;
        dcyc = cyc;
        cap  = sum0;
      end
      step();
    end
    start0 = 1'b0;
    chk("ign_dcnt", W'(dcnt), W'(1));
    chk("ign_dcyc", W'(dcyc), W'(N0 + 1));
    chk("ign_sum", cap, ALTA + W'(1));
    chk("ign_cout", W'(cout0), W'(0));

    // reset in the middle of RUN aborts without a done pulse
    launch(1'b0, 1'b0, ONES, W'(1), 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", W'(busy0), W'(0));
    chk("abort_done", W'(done0), W'(0));
    chk("abort_sum", sum0, W'(0));
    chk("abort_cout", W'(cout0), W'(0));
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done0) dcnt++;
      step();
    end
    chk("abort_nodone", W'(dcnt), W'(0));
    run(tv[0], "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
